// File: rtl/hazard_fwd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl_pkg
// Shared definitions for the pipeline hazard / forwarding controller:
//   - forwarding-mux select encodings
//   - default register-address width
//   - shadow stage-record types for the EX, MEM and WB stages
// -----------------------------------------------------------------------------
package hazard_fwd_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    // Forwarding mux select encodings (EX-stage operand muxes)
    localparam logic [1:0] FWD_REGFILE = 2'b00;  // ID/EX register-file value
    localparam logic [1:0] FWD_EXMEM   = 2'b01;  // EX/MEM ALU result
    localparam logic [1:0] FWD_MEMWB   = 2'b10;  // MEM/WB writeback value

    // Shadow record of the instruction currently in EX
    typedef struct packed {
        logic                  v;
        logic [REG_AW_DEF-1:0] rs;
        logic [REG_AW_DEF-1:0] rt;
        logic                  use_rs;
        logic                  use_rt;
        logic [REG_AW_DEF-1:0] dest;
        logic                  rw;
        logic                  mr;
    } ex_rec_t;

    // Shadow record of the instruction currently in MEM
    typedef struct packed {
        logic                  v;
        logic [REG_AW_DEF-1:0] dest;
        logic                  rw;
        logic                  mr;
    } mem_rec_t;

    // Shadow record of the instruction currently in WB
    typedef struct packed {
        logic                  v;
        logic [REG_AW_DEF-1:0] dest;
        logic                  rw;
    } wb_rec_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_unit.sv
// -----------------------------------------------------------------------------
// fwd_sel_unit
// Combinational forwarding select for one EX-stage ALU operand.
// Ports:
//   ex_v_i, ex_use_i, ex_src_i      EX instruction valid / reads operand / source reg
//   mem_v_i, mem_rw_i, mem_mr_i,
//   mem_dest_i                      MEM-stage producer info
//   wb_v_i, wb_rw_i, wb_dest_i      WB-stage producer info
//   sel_o                           operand mux select (FWD_* encoding)
// -----------------------------------------------------------------------------
module fwd_sel_unit
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              ex_v_i,
    input  logic              ex_use_i,
    input  logic [REG_AW-1:0] ex_src_i,
    input  logic              mem_v_i,
    input  logic              mem_rw_i,
    input  logic              mem_mr_i,
    input  logic [REG_AW-1:0] mem_dest_i,
    input  logic              wb_v_i,
    input  logic              wb_rw_i,
    input  logic [REG_AW-1:0] wb_dest_i,
    output logic [1:0]        sel_o
);

    logic mem_hit;
    logic wb_hit;

    // A load in MEM has no result yet on the EX/MEM path; its value only
    // becomes forwardable from WB. Register 0 is hard-wired and never forwarded.
    assign mem_hit = mem_v_i && mem_rw_i && !mem_mr_i &&
                     (mem_dest_i != '0) && (mem_dest_i == ex_src_i);
    assign wb_hit  = wb_v_i && wb_rw_i &&
                     (wb_dest_i != '0) && (wb_dest_i == ex_src_i);

    always_comb begin
        sel_o = FWD_REGFILE;
        if (ex_v_i && ex_use_i) begin
            // MEM is checked first so the youngest producer wins
            if (mem_hit) begin
                sel_o = FWD_EXMEM;
            end else if (wb_hit) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Central hazard / forwarding controller for a 5-stage pipeline. Tracks shadow
// destination info for EX/MEM/WB, drives the EX operand forwarding selects,
// generates load-use stall and branch flush, and counts stall/flush cycles.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   id_*                           decoded info of the instruction in ID
//   ex_branch_taken                branch resolved taken in EX
//   fwd_a_sel, fwd_b_sel           operand A/B forwarding selects
//   stall, flush                   pipeline hold / squash controls
//   stall_cnt, flush_cnt           free-running (wrapping) event counters
// REG_AW must equal REG_AW_DEF because the stage records use the package width.
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ex_rec_t          ex_q, ex_d;
    mem_rec_t         mem_q;
    wb_rec_t          wb_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic load_use;

    // Dependent instruction in ID right behind a load in EX: the load data is
    // not available until the load reaches WB, so hold ID one cycle.
    assign load_use = id_valid && ex_q.v && ex_q.mr && ex_q.rw && (ex_q.dest != '0) &&
                      ((id_use_rs && (id_rs == ex_q.dest)) ||
                       (id_use_rt && (id_rt == ex_q.dest)));

    // A taken branch squashes the ID instruction, so its load-use is moot.
    assign flush = ex_branch_taken;
    assign stall = load_use && !flush;

    always_comb begin
        ex_d = '0;
        if (!stall && !flush) begin
            ex_d.v      = id_valid;
            ex_d.rs     = id_rs;
            ex_d.rt     = id_rt;
            ex_d.use_rs = id_use_rs;
            ex_d.use_rt = id_use_rt;
            ex_d.dest   = id_dest;
            ex_d.rw     = id_reg_write;
            ex_d.mr     = id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q.v     <= ex_q.v;
            mem_q.dest  <= ex_q.dest;
            mem_q.rw    <= ex_q.rw;
            mem_q.mr    <= ex_q.mr;
            wb_q.v      <= mem_q.v;
            wb_q.dest   <= mem_q.dest;
            wb_q.rw     <= mem_q.rw;
            // Counters wrap naturally at 2^CNT_W
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
            flush_cnt_q <= flush_cnt_q + CNT_W'(flush);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Operand index 0 = A (rs), 1 = B (rt)
    logic [1:0][REG_AW-1:0] ex_src;
    logic [1:0]             ex_use;
    logic [1:0][1:0]        fwd_sel;

    assign ex_src[0] = ex_q.rs;
    assign ex_src[1] = ex_q.rt;
    assign ex_use[0] = ex_q.use_rs;
    assign ex_use[1] = ex_q.use_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel_unit #(
                .REG_AW (REG_AW)
            ) u_fwd_sel (
                .ex_v_i     (ex_q.v),
                .ex_use_i   (ex_use[gi]),
                .ex_src_i   (ex_src[gi]),
                .mem_v_i    (mem_q.v),
                .mem_rw_i   (mem_q.rw),
                .mem_mr_i   (mem_q.mr),
                .mem_dest_i (mem_q.dest),
                .wb_v_i     (wb_q.v),
                .wb_rw_i    (wb_q.rw),
                .wb_dest_i  (wb_q.dest),
                .sel_o      (fwd_sel[gi])
            );
        end
    endgenerate

    assign fwd_a_sel = fwd_sel[0];
    assign fwd_b_sel = fwd_sel[1];

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;   // small counter so wrap is reachable

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
    logic [AW-1:0] id_rs, id_rt, id_dest;
    logic          ex_branch_taken;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          stall, flush;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_fwd_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_dest         (id_dest),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall           (stall),
        .flush           (flush),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [AW-1:0] rs, rt;
        logic          urs, urt;
        logic [AW-1:0] dest;
        logic          rw, mr, br;
        logic [1:0]    ea, eb;
        logic          es, ef;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(logic v, int rs, int rt, logic urs, logic urt, int dest,
                                logic rw, logic mr, logic br,
                                int ea, int eb, logic es, logic ef);
        vec_t t;
        t.v = v; t.rs = AW'(rs); t.rt = AW'(rt); t.urs = urs; t.urt = urt;
        t.dest = AW'(dest); t.rw = rw; t.mr = mr; t.br = br;
        t.ea = 2'(ea); t.eb = 2'(eb); t.es = es; t.ef = ef;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        id_valid        = t.v;
        id_rs           = t.rs;
        id_rt           = t.rt;
        id_use_rs       = t.urs;
        id_use_rt       = t.urt;
        id_dest         = t.dest;
        id_reg_write    = t.rw;
        id_mem_read     = t.mr;
        ex_branch_taken = t.br;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " fwd_a"},     int'(fwd_a_sel), 0);
        chk({tag, " fwd_b"},     int'(fwd_b_sel), 0);
        chk({tag, " stall"},     int'(stall),     0);
        chk({tag, " flush"},     int'(flush),     0);
        chk({tag, " stall_cnt"}, int'(stall_cnt), 0);
        chk({tag, " flush_cnt"}, int'(flush_cnt), 0);
    endtask

    // Watchdog: the run is purely clock-driven, this only guards against a hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t idle, lw2, add6;
        logic [CW-1:0] exp_sc, exp_fc;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw2  = mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0);
        add6 = mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0);

        //            v  rs rt urs urt dst rw mr br  ea eb es ef
        tbl[0]  = mk(1,  1, 2, 1, 1,  3, 1, 0, 0,  0, 0, 0, 0); // add $3,$1,$2
        tbl[1]  = mk(1,  3, 5, 1, 1,  4, 1, 0, 0,  0, 0, 0, 0); // sub $4,$3,$5
        tbl[2]  = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0); // nop; sub in EX -> A=01
        tbl[3]  = mk(1,  1, 1, 1, 1, 10, 1, 0, 0,  0, 0, 0, 0); // add $10
        tbl[4]  = mk(1,  1, 1, 1, 1, 11, 1, 0, 0,  0, 0, 0, 0); // add $11 (independent)
        tbl[5]  = mk(1, 10, 0, 1, 1, 12, 1, 0, 0,  0, 0, 0, 0); // sub $12,$10,$0
        tbl[6]  = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 0, 0); // sub in EX -> A=10
        tbl[7]  = mk(1,  1, 0, 1, 0,  2, 1, 1, 0,  0, 0, 0, 0); // lw $2
        tbl[8]  = mk(1,  2, 0, 1, 0,  6, 1, 1, 0,  0, 0, 1, 0); // lw $6,($2) -> stall
        tbl[9]  = mk(1,  2, 0, 1, 0,  6, 1, 1, 0,  0, 0, 0, 0); // held, bubble in EX
        tbl[10] = mk(1,  6, 6, 1, 1, 19, 1, 0, 0,  2, 0, 1, 0); // add $19,$6,$6 -> stall
        tbl[11] = mk(1,  6, 6, 1, 1, 19, 1, 0, 0,  0, 0, 0, 0); // held, bubble in EX
        tbl[12] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  2, 2, 0, 0); // add19 in EX, lw6 in WB
        tbl[13] = mk(1,  1, 1, 1, 1,  7, 1, 0, 0,  0, 0, 0, 0); // add $7
        tbl[14] = mk(1,  1, 1, 1, 1,  7, 1, 0, 0,  0, 0, 0, 0); // add $7 again
        tbl[15] = mk(1,  1, 7, 1, 1, 13, 1, 0, 0,  0, 0, 0, 0); // add $13,$1,$7
        tbl[16] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 0); // $7 in MEM and WB -> B=01
        tbl[17] = mk(1,  1, 1, 1, 1,  0, 1, 0, 0,  0, 0, 0, 0); // add $0
        tbl[18] = mk(1,  0, 0, 1, 1, 14, 1, 0, 0,  0, 0, 0, 0); // add $14,$0,$0
        tbl[19] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0); // $0 in MEM -> 00
        tbl[20] = mk(1,  1, 0, 1, 0,  0, 1, 1, 0,  0, 0, 0, 0); // lw $0
        tbl[21] = mk(1,  0, 0, 1, 1, 15, 1, 0, 0,  0, 0, 0, 0); // use $0 after lw $0: no stall
        tbl[22] = mk(1,  1, 0, 1, 0,  5, 1, 1, 0,  0, 0, 0, 0); // lw $5
        tbl[23] = mk(1, 15, 5, 1, 1, 16, 1, 0, 1,  0, 0, 0, 1); // load-use + branch -> flush
        tbl[24] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0); // EX bubbled by flush

        // ---------------- reset state ----------------
        drive(idle);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // ---------------- table-driven sequence ----------------
        exp_sc = '0;
        exp_fc = '0;
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1 drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d fwd_a", i),     int'(fwd_a_sel), int'(tbl[i].ea));
            chk($sformatf("row%0d fwd_b", i),     int'(fwd_b_sel), int'(tbl[i].eb));
            chk($sformatf("row%0d stall", i),     int'(stall),     int'(tbl[i].es));
            chk($sformatf("row%0d flush", i),     int'(flush),     int'(tbl[i].ef));
            chk($sformatf("row%0d stall_cnt", i), int'(stall_cnt), int'(exp_sc));
            chk($sformatf("row%0d flush_cnt", i), int'(flush_cnt), int'(exp_fc));
            exp_sc = exp_sc + CW'(tbl[i].es);
            exp_fc = exp_fc + CW'(tbl[i].ef);
        end

        // ---------------- reset asserted mid-stall ----------------
        @(posedge clk);
        #1 drive(lw2);
        @(posedge clk);
        #1 drive(add6);
        @(negedge clk);
        chk("midstall stall", int'(stall), 1);
        chk("midstall stall_cnt", int'(stall_cnt), int'(exp_sc));
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(posedge clk);
        #1 chk("in_reset stall", int'(stall), 0);
        chk("in_reset stall_cnt", int'(stall_cnt), 0);
        drive(idle);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset stall_cnt", int'(stall_cnt), 0);
        chk("post_reset flush_cnt", int'(flush_cnt), 0);

        // ---------------- counter wrap: 17 load-use pairs ----------------
        for (int k = 0; k < 17; k++) begin
            @(posedge clk);
            #1 drive(lw2);
            @(posedge clk);
            #1 drive(add6);
            @(negedge clk);
            chk($sformatf("wrap%0d stall", k), int'(stall), 1);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("wrap%0d held", k), int'(stall), 0);
        end
        @(posedge clk);
        #1 drive(idle);
        @(negedge clk);
        chk("wrap stall_cnt", int'(stall_cnt), 1);
        chk("wrap flush_cnt", int'(flush_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Keeps its own shadow copy of destination-register information for the EX, MEM and WB stages.
- Drives the select lines of the EX-stage ALU operand forwarding muxes (two cascaded 32-bit 2x1 muxes per operand).
- Generates the load-use stall and branch flush controls, and keeps stall/flush performance counters.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  ID source register A.
- id_rt  in  REG_AW  ID source register B.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_dest  in  REG_AW  ID destination register.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- fwd_a_sel  out  2  operand A select: 00 ID/EX regfile value, 01 EX/MEM ALU result, 10 MEM/WB writeback value.
- fwd_b_sel  out  2  operand B select, same encoding.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- flush  out  1  clear IF/ID and ID/EX.
- stall_cnt  out  CNT_W  cycles with stall=1.
- flush_cnt  out  CNT_W  cycles with flush=1.

Behaviour:
- Shadow stage records: EX {v, rs, rt, use_rs, use_rt, dest, rw, mr}; MEM {v, dest, rw, mr}; WB {v, dest, rw}.
- Reset (asynchronous, rst_n=0): all v=0, all counters 0. Outputs then read fwd_*_sel=00, stall=0, flush=0, stall_cnt=0, flush_cnt=0. Reset asserted mid-stall or mid-flush clears everything immediately. No state survives reset.
- Each rising edge: WB<=MEM, MEM<=EX.
  - EX<=ID fields when stall=0 and flush=0.
  - Otherwise EX.v<=0 (bubble).
  - EX.v<=id_valid on a normal advance.
- load_use (combinational): id_valid & EX.v & EX.mr & EX.rw & EX.dest!=0 & ((id_use_rs & id_rs==EX.dest) | (id_use_rt & id_rt==EX.dest)).
- flush = ex_branch_taken. stall = load_use & ~flush. Flush has priority; a simultaneous load-use is discarded because the ID instruction is squashed.
- Stall lasts exactly 1 cycle per load-use. On the next cycle the load is in MEM and forwarding covers it; the MEM-stage load result arrives via the 10 path one cycle later through WB. Back-to-back dependent loads therefore each stall once.
- Forwarding (combinational from shadow state, evaluated for the EX instruction), operand A:
  - sel=01 if EX.v & EX.use_rs & MEM.v & MEM.rw & ~MEM.mr & MEM.dest!=0 & MEM.dest==EX.rs.
  - else sel=10 if EX.v & EX.use_rs & WB.v & WB.rw & WB.dest!=0 & WB.dest==EX.rs.
  - else sel=00.
  - MEM priority over WB gives the youngest producer.
- Operand B: identical rules using rt/use_rt.
- Register 0 is never forwarded and never causes a stall.
- Counters increment by 1 in each cycle their flag is 1. They wrap at 2^CNT_W-1 -> 0, with no saturation.
- No additional latency: stall, flush and fwd selects are valid in the same cycle as their inputs and shadow state.

Decomposition:
- Shared package holds:
  - FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - REG_AW default.
  - The stage-record typedef.
- One sub-module: fwd_sel_unit, the combinational select logic. It is instantiated twice, for operand A and operand B.

Test Plan:
- Reset during a stall: assert rst_n=0 while stall=1 -> all outputs 0 asynchronously, counters 0.
- ALU chain: add $3 then sub $4,$3,$5 back-to-back -> in sub's EX cycle fwd_a_sel=01, stall=0. With one independent instruction between them -> fwd_a_sel=10.
- Load-use: lw $2 then add $6,$2,$2 -> stall=1 for exactly 1 cycle, stall_cnt=1. Next EX cycle fwd_a_sel=fwd_b_sel=10.
- Dual producer: $7 written in both MEM and WB -> fwd_b_sel=01 (MEM wins). Destination $0 in MEM -> sel=00.
- Branch taken coincident with load-use -> flush=1, stall=0, EX bubble, flush_cnt=1, stall_cnt unchanged.
- Counter wrap: with CNT_W=4, 17 consecutive stall-generating load pairs -> stall_cnt=1.
